// File: rtl/saradc_pkg.sv
// saradc_pkg: shared definitions for the SAR ADC controller slice.
//   NB_DEFAULT    : default number of binary-weighted CDAC bits
//   NSAMP_DEFAULT : default sample phase length in clock cycles
//   sar_state_t   : controller state encoding
package saradc_pkg;

  localparam int NB_DEFAULT    = 8;
  localparam int NSAMP_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAMP = 3'd1,
    ST_HOLD = 3'd2,
    ST_CONV = 3'd3,
    ST_DONE = 3'd4
  } sar_state_t;

endpackage

// File: rtl/saradc_sar_bit.sv
// saradc_sar_bit: switch-control register for one CDAC unit.
// The true and complement controls are both taken straight from flops, so
// neither polarity can glitch towards the CDAC switches.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cri_d, crh_d, crl_d : next connect-to-input / high-ref / low-ref controls
//   cri, crh, crl       : registered controls
//   crib, crhb, crlb    : registered complements (all ones in reset)
module saradc_sar_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic cri_d,
  input  logic crh_d,
  input  logic crl_d,
  output logic cri,
  output logic crib,
  output logic crh,
  output logic crhb,
  output logic crl,
  output logic crlb
);

  logic cri_r, crib_r, crh_r, crhb_r, crl_r, crlb_r;

  // Register each control together with its complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cri_r  <= 1'b0;
      crib_r <= 1'b1;
      crh_r  <= 1'b0;
      crhb_r <= 1'b1;
      crl_r  <= 1'b0;
      crlb_r <= 1'b1;
    end else begin
      cri_r  <= cri_d;
      crib_r <= ~cri_d;
      crh_r  <= crh_d;
      crhb_r <= ~crh_d;
      crl_r  <= crl_d;
      crlb_r <= ~crl_d;
    end
  end

  assign cri  = cri_r;
  assign crib = crib_r;
  assign crh  = crh_r;
  assign crhb = crhb_r;
  assign crl  = crl_r;
  assign crlb = crlb_r;

endmodule

// File: rtl/saradc_sar_ctrl.sv
// saradc_sar_ctrl: successive-approximation controller for a binary CDAC.
// Sequence: IDLE -> SAMP (NSAMP cycles) -> HOLD (1 cycle) -> CONV (NB cycles,
// MSB first) -> DONE (1 cycle) -> IDLE, or straight back to SAMP on START.
//   CLK, RSTN      : clock, asynchronous active-low reset
//   VDD, VSS       : supply pins, carried for netlist compatibility only
//   START          : conversion request, honoured only in IDLE and DONE
//   COMP           : comparator decision for the current trial bit
//   CRI/CRH/CRL    : per-bit connect-to-input / high-ref / low-ref controls
//   CRIB/CRHB/CRLB : complements of the above
//   BUSY           : high in SAMP, HOLD and CONV
//   DONE           : one-cycle pulse when DOUT is updated
//   DOUT           : last conversion result
module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int NSAMP = NSAMP_DEFAULT
) (
  input  logic          CLK,
  input  logic          RSTN,
  inout  wire           VDD,
  inout  wire           VSS,
  input  logic          START,
  input  logic          COMP,
  output logic [NB-1:0] CRI,
  output logic [NB-1:0] CRIB,
  output logic [NB-1:0] CRH,
  output logic [NB-1:0] CRHB,
  output logic [NB-1:0] CRL,
  output logic [NB-1:0] CRLB,
  output logic          BUSY,
  output logic          DONE,
  output logic [NB-1:0] DOUT
);

  // One counter serves both the sample phase and the trial-bit index.
  localparam int CMAX = (NB > NSAMP) ? NB : NSAMP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SAMP_LAST = CW'(NSAMP - 1);
  localparam logic [CW-1:0] MSB_IDX   = CW'(NB - 1);

  sar_state_t    state_r, nxt_state_s;
  logic [CW-1:0] cnt_r, nxt_cnt_s;
  logic [NB-1:0] result_r, nxt_result_s;
  logic [NB-1:0] cri_d_s, crh_d_s, crl_d_s;
  logic          busy_r, done_r;
  logic [NB-1:0] dout_r;
  logic          unused_supply_s;

  // The supplies have no logic function.
  assign unused_supply_s = VDD ^ VSS;

  // Next state, counter and partial result.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_cnt_s    = cnt_r;
    nxt_result_s = result_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          nxt_state_s  = ST_SAMP;
          nxt_cnt_s    = SAMP_LAST;
          nxt_result_s = '0;
        end else begin
          nxt_state_s  = ST_IDLE;
        end
      end
      ST_SAMP: begin
        if (cnt_r == '0) begin
          nxt_state_s = ST_HOLD;
        end else begin
          nxt_cnt_s   = cnt_r - CW'(1);
        end
      end
      ST_HOLD: begin
        nxt_state_s = ST_CONV;
        nxt_cnt_s   = MSB_IDX;
      end
      ST_CONV: begin
        // The comparator verdict for trial bit cnt_r lands on this edge.
        for (int j = 0; j < NB; j++) begin
          if (CW'(j) == cnt_r) begin
            nxt_result_s[j] = COMP;
          end else begin
            nxt_result_s[j] = result_r[j];
          end
        end
        if (cnt_r == '0) begin
          nxt_state_s = ST_DONE;
        end else begin
          nxt_cnt_s   = cnt_r - CW'(1);
        end
      end
      ST_DONE: begin
        if (START) begin
          nxt_state_s  = ST_SAMP;
          nxt_cnt_s    = SAMP_LAST;
          nxt_result_s = '0;
        end else begin
          nxt_state_s  = ST_IDLE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = '0;
      end
    endcase
  end

  // CDAC switch pattern for the coming cycle. Decided bits use nxt_result_s
  // so the bit resolved on this very edge is already applied.
  always_comb begin
    cri_d_s = '0;
    crh_d_s = '0;
    crl_d_s = '0;
    case (nxt_state_s)
      ST_SAMP: begin
        cri_d_s = '1;
      end
      ST_CONV: begin
        for (int j = 0; j < NB; j++) begin
          if (CW'(j) == nxt_cnt_s) begin
            crh_d_s[j] = 1'b1;
          end else if (CW'(j) > nxt_cnt_s) begin
            crh_d_s[j] = nxt_result_s[j];
            crl_d_s[j] = ~nxt_result_s[j];
          end else begin
            crl_d_s[j] = 1'b1;
          end
        end
      end
      default: begin
        cri_d_s = '0;
      end
    endcase
  end

  // State, counter, result and status registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dout_r   <= '0;
    end else begin
      state_r  <= nxt_state_s;
      cnt_r    <= nxt_cnt_s;
      result_r <= nxt_result_s;
      busy_r   <= (nxt_state_s == ST_SAMP) || (nxt_state_s == ST_HOLD) ||
                  (nxt_state_s == ST_CONV);
      done_r   <= (nxt_state_s == ST_DONE);
      if (nxt_state_s == ST_DONE) begin
        dout_r <= nxt_result_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign DOUT = dout_r;

  for (genvar g = 0; g < NB; g++) begin : g_bit
    saradc_sar_bit u_bit (
      .clk   (CLK),
      .rst_n (RSTN),
      .cri_d (cri_d_s[g]),
      .crh_d (crh_d_s[g]),
      .crl_d (crl_d_s[g]),
      .cri   (CRI[g]),
      .crib  (CRIB[g]),
      .crh   (CRH[g]),
      .crhb  (CRHB[g]),
      .crl   (CRL[g]),
      .crlb  (CRLB[g])
    );
  end

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb_saradc_sar_ctrl: directed bench for saradc_sar_ctrl (NB=8, NSAMP=2).
// Each conversion pushes its expected DOUT and DONE cycle to a queue; a
// negedge monitor pops it on the expected cycle and checks switch-control
// invariants every cycle.
module tb_saradc_sar_ctrl;

  localparam int NB    = 8;
  localparam int NSAMP = 2;
  localparam int LAT   = NSAMP + NB + 2;

  logic          CLK   = 1'b0;
  logic          RSTN  = 1'b1;
  logic          START = 1'b0;
  logic          COMP  = 1'b0;
  wire           vdd;
  wire           vss;
  logic [NB-1:0] CRI, CRIB, CRH, CRHB, CRL, CRLB;
  logic          BUSY, DONE;
  logic [NB-1:0] DOUT;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [NB-1:0] dout;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  saradc_sar_ctrl #(.NB(NB), .NSAMP(NSAMP)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .VDD   (vdd),
    .VSS   (vss),
    .START (START),
    .COMP  (COMP),
    .CRI   (CRI),
    .CRIB  (CRIB),
    .CRH   (CRH),
    .CRHB  (CRHB),
    .CRL   (CRL),
    .CRLB  (CRLB),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DOUT  (DOUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk8(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Per-cycle invariants plus scoreboard comparison of DONE/DOUT.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk8("crib_inv", CRIB, ~CRI);
      chk8("crhb_inv", CRHB, ~CRH);
      chk8("crlb_inv", CRLB, ~CRL);
      chk8("cri_excl", CRI & (CRH | CRL), 8'h00);
      chk8("crh_crl_excl", CRH & CRL, 8'h00);
      if (exp_q.size() > 0 && cyc == exp_q[0].cyc) begin
        mon_e = exp_q.pop_front();
        chk1("done_pulse", DONE, 1'b1);
        chk8("dout", DOUT, mon_e.dout);
      end else begin
        chk1("done_quiet", DONE, 1'b0);
      end
    end
  end

  // Called at a negedge: raises START for the next edge and drives COMP per
  // trial bit. Returns at the negedge of the DONE cycle.
  task automatic do_conv(input logic [NB-1:0] pat, input bit mid_start,
                         input logic [NB-1:0] hold_val);
    logic [NB-1:0] crh_e, crl_e;
    exp_t          e;
    crh_e = (pat & 8'hC0) | 8'h20;
    crl_e = (~pat & 8'hC0) | 8'h1F;
    START = 1'b1;
    e.dout = pat;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (c >= 4 && c <= NB + 3) COMP = pat[NB + 3 - c];
      if (c == 1) begin
        chk8("samp_cri", CRI, 8'hFF);
        chk8("samp_crh_crl", CRH | CRL, 8'h00);
        chk1("samp_busy", BUSY, 1'b1);
      end
      if (c == 3) begin
        chk8("hold_all_off", CRI | CRH | CRL, 8'h00);
        chk1("hold_busy", BUSY, 1'b1);
      end
      if (c == 6) begin
        chk8("conv_b5_crh", CRH, crh_e);
        chk8("conv_b5_crl", CRL, crl_e);
        chk8("dout_held", DOUT, hold_val);
        if (mid_start) START = 1'b1;
      end
      if (c == LAT) begin
        chk1("done_not_busy", BUSY, 1'b0);
        chk8("done_all_off", CRI | CRH | CRL, 8'h00);
      end
    end
  endtask

  initial begin
    #2 RSTN = 1'b0;
    #1;
    chk8("rst_cri", CRI, 8'h00);
    chk8("rst_crh", CRH, 8'h00);
    chk8("rst_crl", CRL, 8'h00);
    chk8("rst_crib", CRIB, 8'hFF);
    chk8("rst_crhb", CRHB, 8'hFF);
    chk8("rst_crlb", CRLB, 8'hFF);
    chk8("rst_dout", DOUT, 8'h00);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);

    // COMP sequence 1,0,1,0,0,1,0,1
    do_conv(8'hA5, 1'b0, 8'h00);
    @(negedge CLK);
    chk8("dout_after_a5", DOUT, 8'hA5);
    chk1("idle_after_a5", BUSY, 1'b0);

    // all ones then all zeros
    do_conv(8'hFF, 1'b0, 8'hA5);
    @(negedge CLK);
    do_conv(8'h00, 1'b0, 8'hFF);
    @(negedge CLK);

    // START pulsed during CONV must be ignored
    do_conv(8'h3C, 1'b1, 8'h00);
    @(negedge CLK);
    chk1("no_restart_busy", BUSY, 1'b0);
    chk8("dout_after_3c", DOUT, 8'h3C);

    // back-to-back: START held in the DONE cycle
    do_conv(8'h96, 1'b0, 8'h3C);
    do_conv(8'h5A, 1'b0, 8'h96);
    @(negedge CLK);

    // reset in the middle of CONV
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    COMP  = 1'b1;
    repeat (5) @(negedge CLK);
    chk1("pre_rst_busy", BUSY, 1'b1);
    RSTN = 1'b0;
    exp_q.delete();
    #1;
    chk8("mid_rst_cri", CRI, 8'h00);
    chk8("mid_rst_crh", CRH, 8'h00);
    chk8("mid_rst_crl", CRL, 8'h00);
    chk8("mid_rst_crib", CRIB, 8'hFF);
    chk8("mid_rst_crhb", CRHB, 8'hFF);
    chk8("mid_rst_crlb", CRLB, 8'hFF);
    chk8("mid_rst_dout", DOUT, 8'h00);
    chk1("mid_rst_busy", BUSY, 1'b0);
    chk1("mid_rst_done", DONE, 1'b0);
    repeat (3) @(negedge CLK);
    chk8("dout_in_rst", DOUT, 8'h00);

    // first START accepted on the first edge after reset release
    RSTN = 1'b1;
    do_conv(8'hC3, 1'b0, 8'h00);
    repeat (3) @(negedge CLK);
    chk8("dout_final", DOUT, 8'hC3);
    chk32("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
